scroll_sequencer: RTL

//  Sequences the scrolling message window on the 4-digit display.
//  - Owns the message start address (addr) used to read the message memory.
//  - Generates advance requests in two ways: automatically at a selectable

---
 rtl/scroll_pkg.sv | 19 +
 rtl/scroll_tick_gen.sv | 36 +++
 rtl/scroll_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared state encodings, default reload period and speed-shift helper
// for the scrolling message sequencer.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_ARMED = 2'b10
  } state_e;

  localparam logic [22:0] DEFAULT_BASE_PERIOD = 23'h7FFFFF;

  // Each speed step halves the interval between automatic advances.
  function automatic logic [31:0] speed_shift(input logic [31:0] base,
                                              input logic [1:0]  spd);
    return base >> spd;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Reloadable down-counter pacing automatic advances; load wins over en,
// and the count holds at zero until reloaded.
module scroll_tick_gen #(
  parameter int                TICK_W    = 23,
  parameter logic [TICK_W-1:0] RESET_VAL = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  output logic              expired
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TICK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/scroll_sequencer.sv
// Owns the message start address; advances it automatically or on a manual
// step, committing each advance only on a display frame boundary.
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int                ADDR_W      = 4,
  parameter int                MSG_LEN     = 16,
  parameter int                TICK_W      = 23,
  parameter logic [TICK_W-1:0] BASE_PERIOD = TICK_W'(DEFAULT_BASE_PERIOD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_req,
  input  logic              dir,
  input  logic [1:0]        spd,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_upd,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_upd_q, addr_upd_d;
  logic              step_q, step_d;

  logic              step_rise;
  logic              tick_en, tick_load, tick_expired;
  logic              commit;
  logic [TICK_W-1:0] reload_val;
  logic [ADDR_W-1:0] addr_next;

  assign step_rise  = step_req && !step_q;
  assign reload_val = TICK_W'(speed_shift(32'(BASE_PERIOD), spd));

  scroll_tick_gen #(
    .TICK_W    (TICK_W),
    .RESET_VAL (BASE_PERIOD)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .en       (tick_en),
    .load     (tick_load),
    .load_val (reload_val),
    .expired  (tick_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // run takes priority over a coincident step edge in PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: begin
        if (run)            state_d = ST_RUN;
        else if (step_rise) state_d = ST_ARMED;
      end
      ST_RUN: begin
        if (!run)              state_d = ST_PAUSE;
        else if (tick_expired) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (frame_done) state_d = run ? ST_RUN : ST_PAUSE;
      end
      default: state_d = ST_PAUSE;
    endcase
  end

  always_comb begin
    tick_en   = 1'b0;
    tick_load = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_PAUSE: tick_load = run;
      ST_RUN: begin
        tick_load = run && tick_expired;
        tick_en   = run && !tick_expired;
      end
      ST_ARMED: commit = frame_done;
      default: ;
    endcase
  end

  always_comb begin
    if (!dir) begin
      addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end else begin
      addr_next = (addr_q == '0) ? LAST_ADDR : addr_q - ADDR_W'(1);
    end
    addr_d     = commit ? addr_next : addr_q;
    addr_upd_d = commit;
    step_d     = step_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      addr_upd_q <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_upd_q <= addr_upd_d;
      step_q     <= step_d;
    end
  end

  assign addr     = addr_q;
  assign addr_upd = addr_upd_q;
  assign state    = state_q;

endmodule
